// File: rtl/demux2_skid.sv
// 1:2 stream demultiplexer: one producer stream steered per beat to one of two
// consumer channels, each behind its own 2-entry FIFO, with delivered-beat counters.
module demux2_skid #(
   parameter int unsigned bit_length = 64,
   parameter int unsigned cnt_width  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  in_sel,
   input  logic [bit_length-1:0] in_data,
   output logic                  in_ready,
   output logic                  out0_valid,
   output logic [bit_length-1:0] out0_data,
   input  logic                  out0_ready,
   output logic                  out1_valid,
   output logic [bit_length-1:0] out1_data,
   input  logic                  out1_ready,
   output logic [cnt_width-1:0]  cnt0,
   output logic [cnt_width-1:0]  cnt1
);

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   // Per-channel state, index 0/1 = channel 0/1.
   logic [1:0][1:0]           occ_q, occ_d;
   logic [1:0]                wr_ptr_q, wr_ptr_d;
   logic [1:0]                rd_ptr_q, rd_ptr_d;
   logic [1:0][cnt_width-1:0] cnt_q, cnt_d;
   logic [bit_length-1:0]     mem_q [2][2];

   logic [1:0] out_ready;
   logic [1:0] valid;
   logic [1:0] full;
   logic [1:0] pop;
   logic [1:0] push;

   assign out_ready = {out1_ready, out0_ready};

   // Handshake decode. in_ready looks only at the selected channel, so a stalled
   // channel never back-pressures beats bound for the other one.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment so
      // no path leaves it unassigned, which would otherwise infer a latch.
      valid = '0;
      full  = '0;
      pop   = '0;
      push  = '0;
      for (int n = 0; n < 2; n++) begin
         valid[n] = (occ_q[n] != OCC_EMPTY);
         full[n]  = (occ_q[n] == OCC_FULL);
         pop[n]   = valid[n] && out_ready[n];
      end
      in_ready = !full[in_sel] || pop[in_sel];
      push[0]  = in_valid && in_ready && !in_sel;
      push[1]  = in_valid && in_ready &&  in_sel;
   end

   always_comb begin
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      for (int n = 0; n < 2; n++) begin
         // An EMPTY channel has pop=0, so push-on-empty is a plain push (no bypass).
         case ({push[n], pop[n]})
            2'b10:   occ_d[n] = occ_q[n] + 2'd1;
            2'b01:   occ_d[n] = occ_q[n] - 2'd1;
            default: occ_d[n] = occ_q[n];
         endcase
         if (push[n]) wr_ptr_d[n] = ~wr_ptr_q[n];
         if (pop[n]) begin
            rd_ptr_d[n] = ~rd_ptr_q[n];
            cnt_d[n]    = cnt_q[n] + cnt_width'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or process order.
      if (reset) begin
         occ_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; occupancy gates its visibility,
   // and leaving it out of reset lets it map onto plain flops or RAM cells.
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (push[n]) mem_q[n][wr_ptr_q[n]] <= in_data;
      end
   end

   assign out0_valid = valid[0];
   assign out1_valid = valid[1];
   assign out0_data  = mem_q[0][rd_ptr_q[0]];
   assign out1_data  = mem_q[1][rd_ptr_q[1]];
   assign cnt0       = cnt_q[0];
   assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux2_skid.sv
// Directed bench for demux2_skid: stimulus pushes expected beats into per-channel
// queues; a negedge monitor pops and compares whenever a channel hands off a beat.
module tb_demux2_skid;

   localparam int BW = 64;
   localparam int CW = 32;
   localparam int WCW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sel = 1'b0;
   logic [BW-1:0] in_data = '0;
   logic          in_ready;
   logic          out0_valid, out1_valid;
   logic [BW-1:0] out0_data, out1_data;
   logic          out0_ready = 1'b1;
   logic          out1_ready = 1'b1;
   logic [CW-1:0] cnt0, cnt1;

   // Narrow-counter instance used only to exercise counter wrap in few cycles.
   logic           w_in_valid = 1'b0;
   logic           w_in_sel = 1'b1;
   logic [BW-1:0]  w_in_data = '0;
   logic           w_in_ready;
   logic           w_out0_valid, w_out1_valid;
   logic [BW-1:0]  w_out0_data, w_out1_data;
   logic [WCW-1:0] w_cnt0, w_cnt1;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] exp0[$];
   logic [BW-1:0] exp1[$];
   logic [CW-1:0] mcnt0 = '0;
   logic [CW-1:0] mcnt1 = '0;

   always #5 clk = ~clk;

   demux2_skid #(.bit_length(BW), .cnt_width(CW)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
      .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
      .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   demux2_skid #(.bit_length(BW), .cnt_width(WCW)) u_wrap (
      .clk(clk), .reset(reset),
      .in_valid(w_in_valid), .in_sel(w_in_sel), .in_data(w_in_data), .in_ready(w_in_ready),
      .out0_valid(w_out0_valid), .out0_data(w_out0_data), .out0_ready(1'b1),
      .out1_valid(w_out1_valid), .out1_data(w_out1_data), .out1_ready(1'b1),
      .cnt0(w_cnt0), .cnt1(w_cnt1)
   );

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   // Monitor: compares counters against the model every cycle and every delivered beat
   // against the head of its channel's expectation queue.
   always @(negedge clk) begin
      if (!reset) begin
         check("cnt0_track", BW'(cnt0), BW'(mcnt0));
         check("cnt1_track", BW'(cnt1), BW'(mcnt1));
         if (out0_valid && out0_ready) begin
            if (exp0.size() == 0) fail("ch0_spurious_beat");
            else check("ch0_data", out0_data, exp0.pop_front());
            mcnt0 = mcnt0 + 1'b1;
         end
         if (out1_valid && out1_ready) begin
            if (exp1.size() == 0) fail("ch1_spurious_beat");
            else check("ch1_data", out1_data, exp1.pop_front());
            mcnt1 = mcnt1 + 1'b1;
         end
      end
   end

   // Offer one beat for one cycle; exp_rdy is the hand-computed in_ready for that cycle.
   task automatic send(input logic sel, input logic [BW-1:0] data, input logic exp_rdy);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      @(negedge clk);
      check("in_ready", BW'(in_ready), BW'(exp_rdy));
      if (exp_rdy) begin
         if (sel) exp1.push_back(data);
         else     exp0.push_back(data);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int budget = 40;
      while ((exp0.size() != 0 || exp1.size() != 0) && budget > 0) begin
         cycle();
         budget--;
      end
      cycle();
      if (exp0.size() != 0 || exp1.size() != 0) fail("drain_timeout");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle after reset.
      @(negedge clk);
      check("rst_out0_valid", BW'(out0_valid), 0);
      check("rst_out1_valid", BW'(out1_valid), 0);
      check("rst_cnt0", BW'(cnt0), 0);
      check("rst_cnt1", BW'(cnt1), 0);
      in_sel = 1'b0;
      #1 check("idle_ready_sel0", BW'(in_ready), 1);
      in_sel = 1'b1;
      #1 check("idle_ready_sel1", BW'(in_ready), 1);
      cycle();

      // Back-to-back 0xA -> ch0, 0xB -> ch1; one cycle latency, no bypass.
      in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hA;
      @(negedge clk);
      check("no_bypass_ch0", BW'(out0_valid), 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp0.push_back(64'hA);
      in_valid = 1'b1; in_sel = 1'b1; in_data = 64'hB;
      @(negedge clk);
      check("lat_out0_valid", BW'(out0_valid), 1);
      check("lat_out0_data", out0_data, 64'hA);
      check("no_bypass_ch1", BW'(out1_valid), 0);
      exp1.push_back(64'hB);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_out1_valid", BW'(out1_valid), 1);
      check("lat_out1_data", out1_data, 64'hB);
      cycle();
      drain();
      check("t2_cnt0", BW'(cnt0), 1);
      check("t2_cnt1", BW'(cnt1), 1);

      // Stall ch0: two beats fit, third refused, ch1 still flows.
      out0_ready = 1'b0;
      send(1'b0, 64'h1, 1'b1);
      send(1'b0, 64'h2, 1'b1);
      send(1'b0, 64'h3, 1'b0);
      send(1'b1, 64'h9, 1'b1);
      check("stall_full_valid", BW'(out0_valid), 1);
      out0_ready = 1'b1;
      send(1'b0, 64'h3, 1'b1);
      drain();
      check("t3_cnt0", BW'(cnt0), 4);
      check("t3_cnt1", BW'(cnt1), 2);

      // Fill ch0, then a continuous stream through the FULL state.
      out0_ready = 1'b0;
      send(1'b0, 64'h10, 1'b1);
      send(1'b0, 64'h11, 1'b1);
      out0_ready = 1'b1;
      for (int i = 'h12; i <= 'h1F; i++) send(1'b0, BW'(i), 1'b1);
      drain();
      check("t4_cnt0", BW'(cnt0), 20);
      check("t4_cnt1", BW'(cnt1), 2);

      // Reset mid-stream with ch0 FULL and ch1 ONE.
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      send(1'b0, 64'h20, 1'b1);
      send(1'b0, 64'h21, 1'b1);
      send(1'b1, 64'h30, 1'b1);
      reset = 1'b1;
      exp0.delete();
      exp1.delete();
      mcnt0 = '0;
      mcnt1 = '0;
      cycle();
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_out0_valid", BW'(out0_valid), 0);
      check("mid_rst_out1_valid", BW'(out1_valid), 0);
      check("mid_rst_cnt0", BW'(cnt0), 0);
      check("mid_rst_cnt1", BW'(cnt1), 0);
      cycle();
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      send(1'b0, 64'h40, 1'b1);
      send(1'b1, 64'h41, 1'b1);
      drain();
      check("t6_cnt0", BW'(cnt0), 1);
      check("t6_cnt1", BW'(cnt1), 1);

      // Counter wrap on the narrow instance: 255 pops, then one more.
      w_in_sel = 1'b1;
      w_in_valid = 1'b1;
      for (int i = 0; i < 255; i++) begin
         w_in_data = BW'(i);
         @(negedge clk);
         if (w_in_ready !== 1'b1) fail("wrap_in_ready");
         cycle();
      end
      w_in_valid = 1'b0;
      repeat (3) cycle();
      check("wrap_cnt1_max", BW'(w_cnt1), 64'hFF);
      check("wrap_cnt0_idle", BW'(w_cnt0), 0);
      w_in_valid = 1'b1;
      cycle();
      w_in_valid = 1'b0;
      repeat (3) cycle();
      check("wrap_cnt1_zero", BW'(w_cnt1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux2_skid.md
Name: demux2_skid

Overview:
- Operand/result steering block for the execute stage. It is the fan-out counterpart to the 2:1 select mux.
- One 64-bit producer stream is routed to one of two consumer streams, chosen per beat by a select bit.
- Each consumer channel has its own 2-entry buffer, so a stall on one channel never blocks beats bound for the other.
- Per-channel beat counters are provided for pipeline performance statistics.

Parameters:
- bit_length, 64, data width of every channel.
- cnt_width, 32, width of each per-channel delivered-beat counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a beat.
- in_sel  input  1  destination: 0 to channel 0, 1 to channel 1. Meaningful only while in_valid=1.
- in_data  input  bit_length  producer payload.
- in_ready  output  1  beat accepted this cycle when in_valid and in_ready are both 1.
- out0_valid  output  1  channel 0 head entry valid.
- out0_data  output  bit_length  channel 0 head payload.
- out0_ready  input  1  channel 0 consumer accepts head.
- out1_valid  output  1  channel 1 head entry valid.
- out1_data  output  bit_length  channel 1 head payload.
- out1_ready  input  1  channel 1 consumer accepts head.
- cnt0  output  cnt_width  beats delivered on channel 0.
- cnt1  output  cnt_width  beats delivered on channel 1.

Behaviour:
- Each channel has a 2-entry FIFO with a 2-bit occupancy count (0..2), a 1-bit write pointer and a 1-bit read pointer. Both pointers wrap 1 to 0.
- Occupancy states per channel:
  - EMPTY (0): outN_valid=0.
  - ONE (1): outN_valid=1.
  - FULL (2): outN_valid=1.
- outN_data always equals the entry at the read pointer. Its value is don't-care while outN_valid=0.
- in_ready is combinational and equals "selected channel not FULL OR selected channel pops this cycle" (pop = outN_valid and outN_ready).
  - in_ready must not depend on in_valid.
  - in_ready depends on the other channel's state not at all.
- Push: in_valid and in_ready both 1 writes in_data into FIFO[in_sel] at its write pointer. Data is visible on outN_data no earlier than the next cycle, so input-to-output latency is 1 cycle minimum.
- Pop: outN_valid and outN_ready both 1 advances the read pointer and increments cntN by 1. cntN wraps modulo 2^cnt_width with no saturation.
- Push and pop on the same channel in the same cycle:
  - Occupancy is unchanged.
  - This is legal in the FULL state, so full throughput is sustained.
  - In the EMPTY state no bypass occurs: push only, and the state goes to ONE.
- Independent pushes: one channel may be popped while the other is pushed in the same cycle. Only one push per cycle is possible because there is a single input.
- Per-channel ordering is strictly FIFO. There is no ordering guarantee across channels.
- No data loss: a beat offered while in_ready=0 is neither written nor counted. The producer must hold in_valid, in_sel and in_data stable until accepted.
- Reset: when reset=1 at a clock edge, all of the following are cleared, regardless of in-flight beats (a reset mid-stream discards buffered data):
  - occupancies and pointers go to 0;
  - out0_valid=0 and out1_valid=0;
  - cnt0=0 and cnt1=0;
  - FIFO storage contents are don't-care.
- During a reset cycle, in_ready reflects the pre-reset state but accepted data is discarded.
- outN_valid and outN_data are driven from registers only, with no combinational path from in_* to out*_*.

Test Plan:
- Reset, then idle: out0_valid=0, out1_valid=0, cnt0=0, cnt1=0, in_ready=1 for either in_sel.
- Push 0xA (sel0) and 0xB (sel1) back-to-back with both readys=1: out0_data=0xA valid in the cycle after the 0xA push; out1_data=0xB valid in the cycle after the 0xB push; cnt0=1, cnt1=1.
- Hold out0_ready=0 and push 0x1, 0x2, 0x3 to sel0:
  - first two accepted;
  - in_ready=0 on the third;
  - a sel1 beat 0x9 offered meanwhile is accepted and delivered on channel 1;
  - after out0_ready=1, channel 0 delivers 0x1 then 0x2, then accepts and delivers 0x3.
- FULL channel 0 with out0_ready=1 and a continuous sel0 stream 0x10..0x1F: in_ready stays 1, each cycle shows push+pop, order is preserved, cnt0 rises by 16.
- Preload cnt1 to 0xFFFFFFFF (force or drive 2^32-1 pops), then one more pop: cnt1 wraps to 0.
- Channel 0 FULL and channel 1 ONE, assert reset for 1 cycle: next cycle out0_valid=0, out1_valid=0, cnt0=0, cnt1=0, and no stale data reappears on subsequent pushes.
